// File: rtl/tmr_cfg_scrubber.sv
// tmr_cfg_scrubber
//   Owns three copies (A, B, C) of a configuration word and presents their
//   bitwise 2-of-3 majority. All writes go through this block. A scrub,
//   requested either by the periodic timer or by force_scrub, compares the
//   copies and rewrites all three with the voted value if they disagree.
//   Each correction is counted, and the count saturates. A fault-injection
//   port can flip bits in one selected copy.
//
// Ports
//   clk, rst        block clock, synchronous active-high reset
//   wr_en/wr_data   write request and the data to load into all copies
//   wr_ready        high in IDLE, when a write can be accepted
//   wr_ack          one-cycle pulse in the cycle the copies are loaded
//   scrub_en        enables the periodic scrub timer
//   force_scrub     single-cycle scrub request
//   err_cnt_clr     clears err_cnt (takes priority over an increment)
//   inj_en/inj_sel/inj_mask  XOR inj_mask into copy inj_sel (3 = none)
//   q               bitwise majority of the copies
//   mismatch        high when the copies disagree
//   seu_pulse       one-cycle pulse when a correction is written
//   err_cnt         saturating correction counter
//   busy            high when not IDLE
module tmr_cfg_scrubber #(
  parameter int unsigned      WIDTH        = 3,
  parameter logic [WIDTH-1:0] RESET_VAL    = '0,
  parameter int unsigned      SCRUB_PERIOD = 16,
  parameter int unsigned      ERRCNT_W     = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [WIDTH-1:0]    wr_data,
  output logic                wr_ready,
  output logic                wr_ack,
  input  logic                scrub_en,
  input  logic                force_scrub,
  input  logic                err_cnt_clr,
  input  logic                inj_en,
  input  logic [1:0]          inj_sel,
  input  logic [WIDTH-1:0]    inj_mask,
  output logic [WIDTH-1:0]    q,
  output logic                mismatch,
  output logic                seu_pulse,
  output logic [ERRCNT_W-1:0] err_cnt,
  output logic                busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_SCRUB_CHK,
    S_SCRUB_FIX
  } state_t;

  localparam logic [15:0]         C_TIMER_LAST = 16'(SCRUB_PERIOD - 1);
  localparam logic [ERRCNT_W-1:0] C_CNT_MAX    = {ERRCNT_W{1'b1}};

  state_t              r_state;
  state_t              w_state_next;
  logic [WIDTH-1:0]    r_copy_a;
  logic [WIDTH-1:0]    r_copy_b;
  logic [WIDTH-1:0]    r_copy_c;
  logic [WIDTH-1:0]    r_wr_data;
  logic                r_scrub_pend;
  logic [15:0]         r_timer;
  logic [ERRCNT_W-1:0] r_err_cnt;

  logic [WIDTH-1:0]    w_vote;
  logic                w_mismatch;
  logic                w_accept_wr;
  logic                w_take_scrub;
  logic                w_scrub_req;

  // Bitwise 2-of-3 majority.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_vote
      assign w_vote[gi] = (r_copy_a[gi] & r_copy_b[gi]) |
                          (r_copy_a[gi] & r_copy_c[gi]) |
                          (r_copy_b[gi] & r_copy_c[gi]);
    end
  endgenerate

  assign w_mismatch = (r_copy_a != r_copy_b) || (r_copy_b != r_copy_c);

  assign q         = w_vote;
  assign mismatch  = w_mismatch;
  assign wr_ready  = (r_state == S_IDLE);
  assign wr_ack    = (r_state == S_WRITE);
  assign seu_pulse = (r_state == S_SCRUB_FIX);
  assign busy      = (r_state != S_IDLE);
  assign err_cnt   = r_err_cnt;

  always_comb begin
    w_state_next = r_state;
    w_accept_wr  = 1'b0;
    w_take_scrub = 1'b0;
    case (r_state)
      S_IDLE: begin
        // A write wins over a pending scrub; the scrub stays pending.
        if (wr_en) begin
          w_accept_wr  = 1'b1;
          w_state_next = S_WRITE;
        end else if (r_scrub_pend) begin
          w_take_scrub = 1'b1;
          w_state_next = S_SCRUB_CHK;
        end
      end
      S_WRITE:     w_state_next = S_IDLE;
      S_SCRUB_CHK: w_state_next = w_mismatch ? S_SCRUB_FIX : S_IDLE;
      S_SCRUB_FIX: w_state_next = S_IDLE;
      default:     w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_data <= '0;
    end else if (w_accept_wr) begin
      r_wr_data <= wr_data;
    end
  end

  // Copy loads in WRITE / SCRUB_FIX take precedence over injection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_copy_a <= RESET_VAL;
      r_copy_b <= RESET_VAL;
      r_copy_c <= RESET_VAL;
    end else if (r_state == S_WRITE) begin
      r_copy_a <= r_wr_data;
      r_copy_b <= r_wr_data;
      r_copy_c <= r_wr_data;
    end else if (r_state == S_SCRUB_FIX) begin
      r_copy_a <= w_vote;
      r_copy_b <= w_vote;
      r_copy_c <= w_vote;
    end else if (inj_en) begin
      case (inj_sel)
        2'd0:    r_copy_a <= r_copy_a ^ inj_mask;
        2'd1:    r_copy_b <= r_copy_b ^ inj_mask;
        2'd2:    r_copy_c <= r_copy_c ^ inj_mask;
        default: ;
      endcase
    end
  end

  // Free-running period timer, independent of the FSM.
  assign w_scrub_req = force_scrub || (scrub_en && (r_timer == C_TIMER_LAST));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer <= '0;
    end else if (!scrub_en || (r_timer == C_TIMER_LAST)) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + 16'd1;
    end
  end

  // A request arriving while the pending scrub is being consumed merges
  // into that scrub, so consumption clears the flag unconditionally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scrub_pend <= 1'b0;
    end else if (w_take_scrub) begin
      r_scrub_pend <= 1'b0;
    end else if (w_scrub_req) begin
      r_scrub_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || err_cnt_clr) begin
      r_err_cnt <= '0;
    end else if ((r_state == S_SCRUB_FIX) && (r_err_cnt != C_CNT_MAX)) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

endmodule
